// File: rtl/add_pkg.sv
// Shared definitions for the chunked adder sequencer: FSM state type,
// default geometry and small elaboration-time helpers.
package add_pkg;

    // Sequencer states: waiting for operands, stepping slices, holding result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_seq_state_t;

    // Default operand width and slice width
    localparam int ADD_WIDTH = 32;
    localparam int ADD_CHUNK = 8;

    // Number of slice steps needed to cover a full operand
    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Slice index counter width; a single-slice datapath still gets one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Narrow CHUNK-bit adder with carry in/out. Purely combinational; the
// sequencer time-multiplexes one instance across all slices of an operand.
module add_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] full;

    // One extra bit of headroom so the slice carry-out falls out of the add
    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-cycle adder sequencer. Operands are latched on the input handshake,
// then CHUNK-bit slices are pushed LSB first through a single add_slice,
// with the carry held in a register between cycles. The full-width result
// and carry-out are presented on a valid/ready output until taken.
module add_seq_ctrl
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int CHUNK = ADD_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    // Reject geometries the slice schedule cannot cover exactly
    if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
        $fatal(1, "add_seq_ctrl: CHUNK=%0d must be in 1..WIDTH=%0d", CHUNK, WIDTH);
    end
    else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $fatal(1, "add_seq_ctrl: WIDTH=%0d is not a multiple of CHUNK=%0d", WIDTH, CHUNK);
    end

    add_seq_state_t state_q;
    add_seq_state_t state_d;

    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             accept;
    logic             step;
    logic             last;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;

    // The single shared slice adder, fed only from the latched operands
    add_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end
        else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake/control strobes
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~rst;
                accept   = in_valid & ~rst;
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                last = (idx_q == LAST_IDX);
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Select the current operand slices by index
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_slice = a_q[i*CHUNK +: CHUNK];
                b_slice = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // Operand capture, slice stepping and result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end
        else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
        end
        else if (step) begin
            for (int i = 0; i < NCHUNK; i++) begin
                if (idx_q == IDXW'(i)) begin
                    sum[i*CHUNK +: CHUNK] <= slice_sum;
                end
            end
            carry_q <= slice_cout;
            if (last) begin
                cout  <= slice_cout;
                idx_q <= '0;
            end
            else begin
                idx_q <= idx_q + IDXW'(1);
            end
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed self-checking bench for add_seq_ctrl: the default 32/8 geometry
// plus single-slice (32/32) and 16/4 instances for the boundary cases.
module tb_add_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        busy;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_cin;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_busy;

    logic        h_in_valid;
    logic        h_in_ready;
    logic [15:0] h_a;
    logic [15:0] h_b;
    logic        h_cin;
    logic        h_out_valid;
    logic        h_out_ready;
    logic [15:0] h_sum;
    logic        h_cout;
    logic        h_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    add_seq_ctrl #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    add_seq_ctrl #(.WIDTH(32), .CHUNK(32)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .sum(w_sum), .cout(w_cout), .busy(w_busy)
    );

    add_seq_ctrl #(.WIDTH(16), .CHUNK(4)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .cin(h_cin), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .sum(h_sum), .cout(h_cout), .busy(h_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Wait (bounded) for out_valid on the 32/8 instance, returning cycles waited
    task automatic waitDone(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        checkOutput("done_seen", 64'(out_valid), 64'(1));
    endtask

    // Present one operand set to the 32/8 instance and run it to DONE
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic cv, output int lat);
        int n;
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checkOutput("accept", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        waitDone(lat);
    endtask

    initial begin
        int          lat;
        int          lowcnt;
        int          n;
        int          acc;
        int          prev_acc;
        logic [31:0] got_sum;
        logic        got_cout;
        logic [32:0] ref33;
        logic [31:0] wa [2];
        logic [31:0] wb [2];
        logic        wc [2];
        logic [32:0] wexp [2];
        logic [15:0] ha [2];
        logic [15:0] hb [2];
        logic        hc [2];
        logic [16:0] hexp [2];

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_out_ready = 1'b0;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_cin = 1'b0; h_out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("ready_in_reset", 64'(in_ready), 64'(0));
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_sum", 64'(sum), 64'(0));
        checkOutput("rst_cout", 64'(cout), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst", 64'(in_ready), 64'(1));

        // Full carry ripple through every slice
        $display("[TB] full carry ripple");
        out_ready = 1'b1;
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, lat);
        checkOutput("ripple_latency", 64'(lat), 64'(4));
        checkOutput("ripple_sum", 64'(sum), 64'h0);
        checkOutput("ripple_cout", 64'(cout), 64'(1));
        tick();
        checkOutput("ripple_valid_1cyc", 64'(out_valid), 64'(0));
        checkOutput("ripple_idle_ready", 64'(in_ready), 64'(1));

        // Plain add, counting the cycles in_ready stays low
        $display("[TB] plain add");
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
        checkOutput("plain_accept", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        lowcnt = 0;
        got_sum = 'x;
        got_cout = 1'bx;
        while (!in_ready && lowcnt < 20) begin
            if (out_valid) begin
                got_sum = sum;
                got_cout = cout;
            end
            lowcnt++;
            tick();
        end
        checkOutput("plain_ready_low", 64'(lowcnt), 64'(5));
        checkOutput("plain_sum", 64'(got_sum), 64'h2345_6789);
        checkOutput("plain_cout", 64'(got_cout), 64'(0));

        // Backpressure: result held while the consumer stalls
        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
        checkOutput("bp_latency", 64'(lat), 64'(4));
        a = 32'd5; b = 32'd7; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("bp_valid_held", 64'(out_valid), 64'(1));
            checkOutput("bp_sum_held", 64'(sum), 64'h0);
            checkOutput("bp_cout_held", 64'(cout), 64'(1));
            checkOutput("bp_ready_low", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        tick();
        checkOutput("bp_valid_drop", 64'(out_valid), 64'(0));
        checkOutput("bp_ready_back", 64'(in_ready), 64'(1));
        checkOutput("bp_sum_kept", 64'(sum), 64'h0);
        tick();
        checkOutput("bp_second_taken", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        waitDone(lat);
        checkOutput("bp_second_sum", 64'(sum), 64'd12);
        checkOutput("bp_second_cout", 64'(cout), 64'(0));

        // Reset in the second RUN cycle discards the partial result
        $display("[TB] reset mid-op");
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        a = 32'hFFFF_0000; b = 32'h0001_FFFF; cin = 1'b0; in_valid = 1'b1;
        checkOutput("rmid_accept", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("rmid_partial", 64'(sum), 64'h0000_00FF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rmid_valid", 64'(out_valid), 64'(0));
        checkOutput("rmid_sum", 64'(sum), 64'h0);
        checkOutput("rmid_busy", 64'(busy), 64'(0));
        checkOutput("rmid_ready", 64'(in_ready), 64'(1));
        applyStimulus(32'd1, 32'd1, 1'b1, lat);
        checkOutput("rmid_next_sum", 64'(sum), 64'd3);
        checkOutput("rmid_next_cout", 64'(cout), 64'(0));
        checkOutput("rmid_next_lat", 64'(lat), 64'(4));
        tick();

        // Back-to-back with in_valid held high
        $display("[TB] back-to-back");
        out_ready = 1'b1;
        in_valid = 1'b1;
        prev_acc = 0;
        for (int k = 0; k < 10; k++) begin
            a = 32'h9E37_79B9 * 32'(k + 1);
            b = 32'hC6EF_3720 ^ (32'h0101_0101 * 32'(k));
            cin = k[0];
            ref33 = {1'b0, a} + {1'b0, b} + {32'b0, cin};
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            checkOutput("b2b_accept", 64'(in_ready), 64'(1));
            acc = cyc;
            if (k > 0) begin
                checkOutput("b2b_gap", 64'(acc - prev_acc), 64'(6));
            end
            prev_acc = acc;
            tick();
            waitDone(lat);
            checkOutput("b2b_result", 64'({cout, sum}), 64'(ref33));
            if (k == 9) begin
                in_valid = 1'b0;
            end
        end
        tick();
        checkOutput("b2b_idle", 64'(busy), 64'(0));

        // Single-slice geometry: RUN lasts one cycle
        $display("[TB] chunk equals width");
        wa[0] = 32'hFFFF_FFFF; wb[0] = 32'h0000_0001; wc[0] = 1'b1; wexp[0] = 33'h1_0000_0001;
        wa[1] = 32'h7FFF_FFFF; wb[1] = 32'h7FFF_FFFF; wc[1] = 1'b1; wexp[1] = 33'h0_FFFF_FFFF;
        w_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            w_a = wa[k]; w_b = wb[k]; w_cin = wc[k]; w_in_valid = 1'b1;
            checkOutput("w_accept", 64'(w_in_ready), 64'(1));
            tick();
            w_in_valid = 1'b0;
            checkOutput("w_run_busy", 64'(w_busy), 64'(1));
            checkOutput("w_run_no_valid", 64'(w_out_valid), 64'(0));
            tick();
            checkOutput("w_done", 64'(w_out_valid), 64'(1));
            checkOutput("w_result", 64'({w_cout, w_sum}), 64'(wexp[k]));
            tick();
        end

        // 16/4 geometry: four slices over a narrower word
        $display("[TB] width 16 chunk 4");
        ha[0] = 16'hFFFF; hb[0] = 16'h0001; hc[0] = 1'b0; hexp[0] = 17'h1_0000;
        ha[1] = 16'h1234; hb[1] = 16'h4321; hc[1] = 1'b1; hexp[1] = 17'h0_5556;
        h_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            h_a = ha[k]; h_b = hb[k]; h_cin = hc[k]; h_in_valid = 1'b1;
            checkOutput("h_accept", 64'(h_in_ready), 64'(1));
            tick();
            h_in_valid = 1'b0;
            lat = 0;
            while (!h_out_valid && lat < 100) begin
                tick();
                lat++;
            end
            checkOutput("h_latency", 64'(lat), 64'(4));
            checkOutput("h_result", 64'({h_cout, h_sum}), 64'(hexp[k]));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
